// File: rtl/ddr_rd_checker.sv
// ddr_rd_checker: checks DDR read-back bytes against a counter pattern, or an LFSR pattern when RD_CHK_PRBS_EN is defined
module ddr_rd_checker #(
   parameter int          BURST_LEN  = 16,
   parameter logic [29:0] ADDR_BEGIN = 30'h0,
   parameter int          TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_calib_complete,
   input  logic        start,
   output logic        rd_enable,
   output logic [29:0] rd_addr_begin,
   input  logic        rd_valid_in,
   input  logic [7:0]  rd_data_in,
   output logic        busy,
   output logic        done,
   output logic        tg_compare_error,
   output logic [15:0] err_count,
   output logic [15:0] first_err_idx,
   output logic        rd_timeout
);
   localparam logic [15:0] LAST     = 16'(BURST_LEN - 1);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   typedef enum logic [2:0] {IDLE, WAIT_CAL, REQ, RECV, DONE} state_t;
   state_t state, state_nxt;
   logic [15:0] idx, tmo;
   logic [7:0] exp_byte;
   logic go, acc, mis, last, tmo_hit;
   assign rd_addr_begin = ADDR_BEGIN;
   assign go      = state == IDLE && start;
   assign acc     = state == RECV && rd_valid_in;
   assign mis     = acc && rd_data_in != exp_byte;
   assign last    = acc && idx == LAST;
   assign tmo_hit = state == RECV && !rd_valid_in && tmo == TMO_LAST;
`ifdef RD_CHK_PRBS_EN
   logic [7:0] lfsr;
   assign exp_byte = lfsr;
   always_ff @(posedge clk) begin
      if (rst || go)
         lfsr <= 8'hFF;
      else if (acc)
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
`else
   assign exp_byte = idx[7:0];
`endif
   always_comb begin
      state_nxt = state;
      rd_enable = state == REQ;
      busy      = state != IDLE;
      done      = state == DONE;
      case (state)
         IDLE:     if (start) state_nxt = init_calib_complete ? REQ : WAIT_CAL;
         WAIT_CAL: if (init_calib_complete) state_nxt = REQ;
         REQ:      state_nxt = RECV;
         RECV:     if (last || tmo_hit) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         idx              <= '0;
         tmo              <= '0;
         err_count        <= '0;
         first_err_idx    <= '0;
         tg_compare_error <= 1'b0;
         rd_timeout       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (go) begin
            idx              <= '0;
            tmo              <= '0;
            err_count        <= '0;
            first_err_idx    <= '0;
            tg_compare_error <= 1'b0;
            rd_timeout       <= 1'b0;
         end
         if (acc) begin
            idx <= idx + 16'd1;
            tmo <= '0;
         end else if (state == RECV)
            tmo <= tmo + 16'd1;
         // err_count is still zero only before the first mismatch of the run
         if (mis) begin
            err_count        <= err_count + 16'(err_count != 16'hFFFF);
            tg_compare_error <= 1'b1;
            if (err_count == '0) first_err_idx <= idx;
         end
         if (tmo_hit) begin
            rd_timeout       <= 1'b1;
            tg_compare_error <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ddr_rd_checker.sv
// tb_ddr_rd_checker: scoreboard bench; expected run results are queued as bytes are driven and checked on done
module tb_ddr_rd_checker;
   localparam int          BL  = 16;
   localparam int          TMO = 8;
   localparam logic [29:0] AB  = 30'h2345678;
   typedef struct {
      logic [15:0] ec;
      logic [15:0] fi;
      logic        tg;
      logic        to;
   } res_t;
   logic clk = 1'b0;
   logic rst, init_calib_complete, start, rd_valid_in;
   logic [7:0] rd_data_in;
   logic rd_enable, busy, done, tg_compare_error, rd_timeout;
   logic [29:0] rd_addr_begin;
   logic [15:0] err_count, first_err_idx;
   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] pat [BL];
   res_t sb [$];
   res_t m;
   ddr_rd_checker #(.BURST_LEN(BL), .ADDR_BEGIN(AB), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete), .start(start),
      .rd_enable(rd_enable), .rd_addr_begin(rd_addr_begin), .rd_valid_in(rd_valid_in),
      .rd_data_in(rd_data_in), .busy(busy), .done(done), .tg_compare_error(tg_compare_error),
      .err_count(err_count), .first_err_idx(first_err_idx), .rd_timeout(rd_timeout)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   function automatic logic [7:0] model_exp(input int i);
`ifdef RD_CHK_PRBS_EN
      logic [7:0] q = 8'hFF;
      for (int k = 0; k < i; k++) q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
      return q;
`else
      return 8'(i);
`endif
   endfunction
   task automatic clean_pat;
      for (int i = 0; i < BL; i++) pat[i] = model_exp(i);
   endtask
   task automatic start_run(input int cal_delay);
      int seen = 0;
      init_calib_complete = cal_delay == 0;
      start = 1'b1;
      step;
      start = 1'b0;
      if (cal_delay > 0) begin
         check("cal_busy", busy, 1);
         for (int k = 0; k < cal_delay - 1; k++) begin
            seen += int'(rd_enable);
            step;
         end
         check("cal_no_rden", seen, 0);
         init_calib_complete = 1'b1;
         step;
      end
      check("rden_on", rd_enable, 1);
      check("addr", rd_addr_begin, AB);
      step;
      check("rden_1cyc", rd_enable, 0);
   endtask
   task automatic send(input int n, input int gap, input int start_at);
      res_t r;
      int lat;
      r.ec = '0;
      r.fi = '0;
      for (int i = 0; i < n; i++)
         if (pat[i] != model_exp(i)) begin
            if (r.ec == 0) r.fi = 16'(i);
            r.ec++;
         end
      r.to = n < BL;
      r.tg = r.to || r.ec != 0;
      sb.push_back(r);
      for (int i = 0; i < n; i++) begin
         rd_valid_in = 1'b1;
         rd_data_in  = pat[i];
         start       = i == start_at;
         step;
         rd_valid_in = 1'b0;
         rd_data_in  = 8'h5A;
         start       = 1'b0;
         if (i < n - 1) repeat (gap) step;
      end
      lat = 1;
      while (!done && lat < 40) begin
         step;
         lat++;
      end
      check("done_lat", lat, r.to ? TMO + 1 : 1);
      step;
      check("done_pulse", done, 0);
      check("idle", busy, 0);
      check("hold_ec", err_count, r.ec);
      check("hold_to", rd_timeout, r.to);
   endtask
   always @(negedge clk)
      if (done) begin
         if (sb.size() == 0)
            check("sb_empty", 1, 0);
         else begin
            m = sb.pop_front();
            check("err_count", err_count, m.ec);
            check("first_err_idx", first_err_idx, m.fi);
            check("tg_compare_error", tg_compare_error, m.tg);
            check("rd_timeout", rd_timeout, m.to);
         end
      end
   initial begin
      rst = 1'b1;
      init_calib_complete = 1'b1;
      start = 1'b0;
      rd_valid_in = 1'b0;
      rd_data_in = '0;
      repeat (3) step;
      check("rst_busy", busy, 0);
      check("rst_rden", rd_enable, 0);
      check("rst_done", done, 0);
      check("rst_ec", err_count, 0);
      check("rst_fi", first_err_idx, 0);
      check("rst_tg", tg_compare_error, 0);
      check("rst_to", rd_timeout, 0);
      check("rst_addr", rd_addr_begin, AB);
      rst = 1'b0;
      step;
      clean_pat;
      start_run(0);
      send(BL, 0, -1);
      clean_pat;
      pat[5] = 8'hAA;
      start_run(0);
      send(BL, 0, -1);
      for (int i = 0; i < BL; i++) pat[i] = 8'(i);
      start_run(0);
      send(BL, 0, -1);
      clean_pat;
      pat[9]  = pat[9] ^ 8'h01;
      pat[15] = pat[15] ^ 8'h80;
      start_run(0);
      send(BL, 1, -1);
      clean_pat;
      start_run(0);
      send(BL, TMO - 1, -1);
      clean_pat;
      start_run(0);
      send(10, 3, -1);
      clean_pat;
      pat[12] = ~pat[12];
      start_run(20);
      send(BL, 0, 3);
      clean_pat;
      pat[2] = ~pat[2];
      start_run(0);
      for (int i = 0; i < 7; i++) begin
         rd_valid_in = 1'b1;
         rd_data_in  = pat[i];
         step;
      end
      rst = 1'b1;
      rd_data_in = pat[7];
      step;
      rst = 1'b0;
      rd_valid_in = 1'b0;
      check("mid_busy", busy, 0);
      check("mid_rden", rd_enable, 0);
      check("mid_done", done, 0);
      check("mid_ec", err_count, 0);
      check("mid_fi", first_err_idx, 0);
      check("mid_tg", tg_compare_error, 0);
      check("mid_to", rd_timeout, 0);
      repeat (2) step;
      clean_pat;
      start_run(0);
      send(BL, 0, -1);
      repeat (3) step;
      check("sb_drain", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
